beat_deserializer: RTL and testbench
====================================

Name: beat_deserializer

Overview:
- Receive side of the narrow-beat stream link; the counterpart to the team's beat serializer.
- Accepts BEAT_W-bit beats on a valid/ready slave port and packs BEATS consecutive beats into one wide word on a valid/ready master port.
- An early s_last flushes a partial word, with a per-beat keep mask.
- Sits between the link receiver and wide-datapath consumers.

Parameters:
- BEAT_W, 8: width of one input beat in bits; legal range is 1 or greater.
- BEATS, 4: beats per output word; legal range is 2 or greater.
- MSB_FIRST, 0: 0 places the first beat in m_data[BEAT_W-1:0]; 1 places the first beat in the top slice.
- CNT_W, $clog2(BEATS): beat counter width. This is a localparam and is not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- s_valid  input  1  input beat valid
- s_ready  output  1  input beat accepted when s_valid && s_ready
- s_data  input  BEAT_W  beat payload
- s_last  input  1  final beat of packet; closes the current word
- m_valid  output  1  output word valid
- m_ready  input  1  downstream accepts the word when m_valid && m_ready
- m_data  output  BEAT_W*BEATS  packed word
- m_keep  output  BEATS  bit i set means beat slot i holds received data (slot 0 = first beat)
- m_last  output  1  word ends a packet
- m_count  output  CNT_W+1  number of valid beats in the word, range 1..BEATS

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: m_valid=0, m_data=0, m_keep=0, m_last=0, m_count=0. Internal beat counter=0, accumulator=0, accumulated keep=0.
- Reset deassertion is synchronised by the integrator, not in this block.
- s_ready = !m_valid || m_ready. This is combinational and does not depend on s_valid, s_data or s_last.
- Beat accept (s_valid && s_ready):
  - Slot index = counter. With MSB_FIRST=0 the slice is [idx*BEAT_W +: BEAT_W]; with MSB_FIRST=1 it is [(BEATS-1-idx)*BEAT_W +: BEAT_W].
  - If counter==BEATS-1 or s_last=1, the word completes. On the next edge:
    - m_data = accumulator with the current beat merged in, and unused slots forced to 0.
    - m_keep = accumulated keep | current slot bit.
    - m_count = counter+1.
    - m_last = s_last.
    - m_valid=1.
    - Counter, accumulator and keep are cleared.
  - Otherwise the beat is stored in the accumulator, its keep bit is set, and the counter increments.
- Latency: one cycle from the completing beat's accept edge to m_valid high. Throughput is one beat per cycle with no bubbles while m_ready=1.
- Output hold:
  - While m_valid && !m_ready, m_data, m_keep, m_last and m_count are stable and s_ready=0.
  - The counter and accumulator stay frozen, so partial-word state is retained across stalls.
- Simultaneous events: if m_valid && m_ready occurs in the same cycle a new word completes, m_valid stays 1 and the outputs take the new word (back-to-back, no gap).
- Output retire: m_valid && m_ready with no completing beat in that cycle clears m_valid next edge. The data outputs hold their last value and are don't-care.
- s_last with counter==0 produces a 1-beat word: m_keep=0...01 and m_count=1.
- s_last on slot BEATS-1 gives a full keep mask with m_last=1.
- Counter wraps only through completion; it never exceeds BEATS-1.
- Reset mid-word: the partial word is discarded and no output is produced. Reset while m_valid=1 drops the word.
- s_data, s_last are sampled only on accept. Values while !s_valid are ignored.
- There is no internal FIFO; the storage depth is one assembling word plus one output word.

Test Plan:
- Beats 0x11, 0x22, 0x33, 0x44 with no last, m_ready=1, defaults -> one cycle after the 4th beat: m_data=0x44332211, m_keep=4'b1111, m_count=4, m_last=0.
- Same stimulus with MSB_FIRST=1 -> m_data=0x11223344.
- Beats 0xAA, 0xBB with s_last on 0xBB -> m_data=0x0000BBAA, m_keep=4'b0011, m_count=2, m_last=1. Then one beat 0xCC with s_last -> m_keep=4'b0001, m_data=0x000000CC.
- 12 back-to-back beats 0x01..0x0C with m_ready=1 -> three words 0x04030201, 0x08070605, 0x0C0B0A09 on consecutive-completion cycles, s_ready constant 1.
- Complete a word, hold m_ready=0 for 5 cycles -> s_ready=0, outputs stable, no beats lost. Release -> next 4 beats assemble correctly.
- Reset pulse (rst_n low, mid-cycle) after 2 of 4 beats -> all outputs 0 immediately. The next 4 beats 0x01..0x04 produce exactly 0x04030201.

Source files
------------

// File: rtl/beat_deserializer.sv
// beat_deserializer: packs BEATS narrow beats from a valid/ready slave port into one
// wide word on a valid/ready master port. An early s_last flushes a partial word, and
// m_keep/m_count describe which beat slots hold received data.
module beat_deserializer #(
   parameter int unsigned  BEAT_W    = 8,
   parameter int unsigned  BEATS     = 4,
   parameter int unsigned  MSB_FIRST = 0,
   localparam int unsigned CNT_W     = $clog2(BEATS)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [BEAT_W-1:0]       s_data,
   input  logic                    s_last,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [BEAT_W*BEATS-1:0] m_data,
   output logic [BEATS-1:0]        m_keep,
   output logic                    m_last,
   output logic [CNT_W:0]          m_count
);

   localparam int unsigned      WORD_W   = BEAT_W * BEATS;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

   // Assembling word state
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WORD_W-1:0] acc_q, acc_d;
   logic [BEATS-1:0]  keep_q, keep_d;

   // Output word registers
   logic              m_valid_q, m_valid_d;
   logic [WORD_W-1:0] m_data_q, m_data_d;
   logic [BEATS-1:0]  m_keep_q, m_keep_d;
   logic              m_last_q, m_last_d;
   logic [CNT_W:0]    m_count_q, m_count_d;

   logic              accept;
   logic              complete;
   logic [WORD_W-1:0] merged;
   logic [BEATS-1:0]  keep_merged;

   // The output register can take a new word whenever it is empty or being drained.
   assign s_ready  = !m_valid_q || m_ready;
   assign accept   = s_valid && s_ready;
   assign complete = accept && ((cnt_q == LAST_IDX) || s_last);

   // Merge the incoming beat into its data slice and set its keep bit.
   always_comb begin
      merged      = acc_q;
      keep_merged = keep_q;
      for (int i = 0; i < BEATS; i++) begin
         if (cnt_q == CNT_W'(i)) begin
            keep_merged[i] = 1'b1;
            if (MSB_FIRST != 0) begin
               merged[(BEATS-1-i)*BEAT_W +: BEAT_W] = s_data;
            end else begin
               merged[i*BEAT_W +: BEAT_W] = s_data;
            end
         end
      end
   end

   // Next-state: retire, complete (possibly in the same cycle) or accumulate.
   always_comb begin
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      keep_d    = keep_q;
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      m_keep_d  = m_keep_q;
      m_last_d  = m_last_q;
      m_count_d = m_count_q;
      if (m_valid_q && m_ready) begin
         m_valid_d = 1'b0;
      end
      if (complete) begin
         // Unused slots are already zero: the accumulator is cleared on every completion.
         m_valid_d = 1'b1;
         m_data_d  = merged;
         m_keep_d  = keep_merged;
         m_last_d  = s_last;
         m_count_d = {1'b0, cnt_q} + (CNT_W+1)'(1);
         cnt_d     = '0;
         acc_d     = '0;
         keep_d    = '0;
      end else if (accept) begin
         acc_d  = merged;
         keep_d = keep_merged;
         cnt_d  = cnt_q + CNT_W'(1);
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         acc_q     <= '0;
         keep_q    <= '0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_keep_q  <= '0;
         m_last_q  <= 1'b0;
         m_count_q <= '0;
      end else begin
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         keep_q    <= keep_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         m_keep_q  <= m_keep_d;
         m_last_q  <= m_last_d;
         m_count_q <= m_count_d;
      end
   end

   assign m_valid = m_valid_q;
   assign m_data  = m_data_q;
   assign m_keep  = m_keep_q;
   assign m_last  = m_last_q;
   assign m_count = m_count_q;

endmodule

// File: tb/tb_beat_deserializer.sv
// Testbench for beat_deserializer: LSB-first and MSB-first instances share one stimulus
// stream; a beat-queue reference model predicts every output word.
module tb_beat_deserializer;

   localparam int unsigned NB = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        s_valid = 1'b0;
   logic        s_last = 1'b0;
   logic        m_ready = 1'b0;
   logic [7:0]  s_data = 8'h00;

   logic        s_ready_a, s_ready_b, m_valid_a, m_valid_b, m_last_a, m_last_b;
   logic [31:0] m_data_a, m_data_b;
   logic [3:0]  m_keep_a, m_keep_b;
   logic [2:0]  m_count_a, m_count_b;

   int total = 0;
   int bad = 0;

   // Reference model: beats of the word being assembled plus the pending output word
   logic [7:0]  beats_m[$];
   logic        mv_m;
   logic [31:0] md_lsb_m, md_msb_m;
   logic [3:0]  mk_m;
   logic [2:0]  mc_m;
   logic        ml_m;
   logic        sr_seen;

   always #5 clk = ~clk;

   beat_deserializer #(.BEAT_W(8), .BEATS(4), .MSB_FIRST(0)) dut_a (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_a), .s_data(s_data),
      .s_last(s_last), .m_valid(m_valid_a), .m_ready(m_ready), .m_data(m_data_a),
      .m_keep(m_keep_a), .m_last(m_last_a), .m_count(m_count_a)
   );

   beat_deserializer #(.BEAT_W(8), .BEATS(4), .MSB_FIRST(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_b), .s_data(s_data),
      .s_last(s_last), .m_valid(m_valid_b), .m_ready(m_ready), .m_data(m_data_b),
      .m_keep(m_keep_b), .m_last(m_last_b), .m_count(m_count_b)
   );

   task automatic model_clear();
      beats_m.delete();
      mv_m = 1'b0; md_lsb_m = '0; md_msb_m = '0; mk_m = '0; mc_m = '0; ml_m = 1'b0;
   endtask

   // Drive one cycle from a negedge, update the model at the posedge, return at the negedge.
   task automatic drive_cycle(input logic sv, input logic [7:0] sd, input logic sl,
                              input logic mr);
      logic acc;
      s_valid = sv; s_data = sd; s_last = sl; m_ready = mr;
      #1;
      sr_seen = s_ready_a;
      acc = sv && (!mv_m || mr);
      @(posedge clk);
      if (mv_m && mr) mv_m = 1'b0;
      if (acc) begin
         beats_m.push_back(sd);
         if (beats_m.size() == NB || sl) begin
            md_lsb_m = '0;
            md_msb_m = '0;
            foreach (beats_m[i]) begin
               md_lsb_m = md_lsb_m | (32'(beats_m[i]) << (8 * i));
               md_msb_m = md_msb_m | (32'(beats_m[i]) << (8 * (3 - i)));
            end
            mk_m = 4'((1 << beats_m.size()) - 1);
            mc_m = 3'(beats_m.size());
            ml_m = sl;
            mv_m = 1'b1;
            beats_m.delete();
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_clear();
      @(negedge clk);
      @(negedge clk);
      total++; if (m_valid_a !== 1'b0 || m_valid_b !== 1'b0) begin
         bad++; $display("FAIL reset_valid got=%b/%b exp=0", m_valid_a, m_valid_b); end
      total++; if (m_data_a !== 32'h0 || m_data_b !== 32'h0) begin
         bad++; $display("FAIL reset_data got=%h/%h exp=0", m_data_a, m_data_b); end
      total++; if (m_keep_a !== 4'h0 || m_count_a !== 3'd0 || m_last_a !== 1'b0) begin
         bad++; $display("FAIL reset_side got keep=%h cnt=%0d last=%b exp=0", m_keep_a,
                         m_count_a, m_last_a); end
      total++; if (s_ready_a !== 1'b1) begin
         bad++; $display("FAIL reset_s_ready got=%b exp=1", s_ready_a); end
      rst_n = 1'b1;
   endtask

   task automatic test_full_word();
      for (int i = 0; i < 4; i++) drive_cycle(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b1);
      total++; if (m_valid_a !== 1'b1 || m_data_a !== 32'h44332211) begin
         bad++; $display("FAIL full_lsb got v=%b d=%h exp v=1 d=44332211", m_valid_a, m_data_a); end
      total++; if (m_data_b !== 32'h11223344) begin
         bad++; $display("FAIL full_msb got=%h exp=11223344", m_data_b); end
      total++; if (m_keep_a !== 4'hf || m_count_a !== 3'd4 || m_last_a !== 1'b0) begin
         bad++; $display("FAIL full_side got keep=%h cnt=%0d last=%b exp f/4/0", m_keep_a,
                         m_count_a, m_last_a); end
      drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
      total++; if (m_valid_a !== 1'b0) begin
         bad++; $display("FAIL full_retire got=%b exp=0", m_valid_a); end
   endtask

   task automatic test_partial();
      drive_cycle(1'b1, 8'hAA, 1'b0, 1'b1);
      drive_cycle(1'b1, 8'hBB, 1'b1, 1'b1);
      total++; if (m_valid_a !== 1'b1 || m_data_a !== 32'h0000BBAA || m_data_b !== 32'hAABB0000)
      begin
         bad++; $display("FAIL partial_data got v=%b %h/%h exp 1 0000bbaa/aabb0000", m_valid_a,
                         m_data_a, m_data_b); end
      total++; if (m_keep_a !== 4'b0011 || m_count_a !== 3'd2 || m_last_a !== 1'b1) begin
         bad++; $display("FAIL partial_side got keep=%b cnt=%0d last=%b exp 0011/2/1", m_keep_a,
                         m_count_a, m_last_a); end
      drive_cycle(1'b1, 8'hCC, 1'b1, 1'b1);
      total++; if (m_valid_a !== 1'b1 || m_data_a !== 32'h000000CC || m_data_b !== 32'hCC000000)
      begin
         bad++; $display("FAIL single_data got v=%b %h/%h exp 1 000000cc/cc000000", m_valid_a,
                         m_data_a, m_data_b); end
      total++; if (m_keep_a !== 4'b0001 || m_count_a !== 3'd1 || m_last_a !== 1'b1) begin
         bad++; $display("FAIL single_side got keep=%b cnt=%0d last=%b exp 0001/1/1", m_keep_a,
                         m_count_a, m_last_a); end
      drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_w [3];
      exp_w[0] = 32'h04030201; exp_w[1] = 32'h08070605; exp_w[2] = 32'h0C0B0A09;
      for (int i = 0; i < 12; i++) begin
         drive_cycle(1'b1, 8'(i + 1), 1'b0, 1'b1);
         total++; if (sr_seen !== 1'b1) begin
            bad++; $display("FAIL b2b_s_ready beat=%0d got=%b exp=1", i, sr_seen); end
         if (i % 4 == 3) begin
            total++; if (m_valid_a !== 1'b1 || m_data_a !== exp_w[i/4]) begin
               bad++; $display("FAIL b2b_word%0d got v=%b d=%h exp 1 %h", i / 4, m_valid_a,
                               m_data_a, exp_w[i/4]); end
         end
      end
      drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
   endtask

   task automatic test_stall();
      for (int i = 0; i < 3; i++) drive_cycle(1'b1, 8'(8'h21 + i), 1'b0, 1'b1);
      drive_cycle(1'b1, 8'h24, 1'b0, 1'b0);
      for (int c = 0; c < 5; c++) begin
         drive_cycle(1'b1, 8'h31, 1'b0, 1'b0);
         total++; if (sr_seen !== 1'b0 || s_ready_b !== 1'b0) begin
            bad++; $display("FAIL stall_s_ready cyc=%0d got=%b exp=0", c, sr_seen); end
         total++; if (m_valid_a !== 1'b1 || m_data_a !== 32'h24232221 || m_keep_a !== 4'hf ||
                      m_count_a !== 3'd4) begin
            bad++; $display("FAIL stall_hold cyc=%0d got v=%b d=%h k=%h c=%0d exp 1 24232221 f 4",
                            c, m_valid_a, m_data_a, m_keep_a, m_count_a); end
      end
      drive_cycle(1'b1, 8'h31, 1'b0, 1'b1);
      total++; if (sr_seen !== 1'b1) begin
         bad++; $display("FAIL stall_release got=%b exp=1", sr_seen); end
      for (int i = 0; i < 3; i++) drive_cycle(1'b1, 8'(8'h32 + i), 1'b0, 1'b1);
      total++; if (m_valid_a !== 1'b1 || m_data_a !== 32'h34333231 || m_data_b !== 32'h31323334)
      begin
         bad++; $display("FAIL stall_next got v=%b %h/%h exp 1 34333231/31323334", m_valid_a,
                         m_data_a, m_data_b); end
      drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
   endtask

   task automatic test_reset_mid();
      drive_cycle(1'b1, 8'h01, 1'b0, 1'b1);
      drive_cycle(1'b1, 8'h02, 1'b0, 1'b1);
      s_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (m_valid_a !== 1'b0 || m_data_a !== 32'h0 || m_keep_a !== 4'h0 ||
                   m_count_a !== 3'd0 || m_data_b !== 32'h0) begin
         bad++; $display("FAIL midreset_outputs got v=%b d=%h k=%h c=%0d exp all 0", m_valid_a,
                         m_data_a, m_keep_a, m_count_a); end
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) drive_cycle(1'b1, 8'(i + 1), 1'b0, 1'b1);
      total++; if (m_valid_a !== 1'b1 || m_data_a !== 32'h04030201 || m_keep_a !== 4'hf ||
                   m_count_a !== 3'd4) begin
         bad++; $display("FAIL midreset_next got v=%b d=%h k=%h c=%0d exp 1 04030201 f 4",
                         m_valid_a, m_data_a, m_keep_a, m_count_a); end
      drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
   endtask

   task automatic test_random();
      logic sv, sl, mr, exp_sr;
      logic [7:0] sd;
      for (int c = 0; c < 400; c++) begin
         sv = ($urandom_range(0, 3) != 0);
         sl = ($urandom_range(0, 4) == 0);
         mr = ($urandom_range(0, 3) != 0);
         sd = 8'($urandom);
         exp_sr = !mv_m || mr;
         drive_cycle(sv, sd, sl, mr);
         total++; if (sr_seen !== exp_sr) begin
            bad++; $display("FAIL rand_s_ready cyc=%0d got=%b exp=%b", c, sr_seen, exp_sr); end
         total++; if (m_valid_a !== mv_m || m_valid_b !== mv_m) begin
            bad++; $display("FAIL rand_valid cyc=%0d got=%b/%b exp=%b", c, m_valid_a, m_valid_b,
                            mv_m); end
         if (mv_m) begin
            total++; if (m_data_a !== md_lsb_m || m_data_b !== md_msb_m) begin
               bad++; $display("FAIL rand_data cyc=%0d got=%h/%h exp=%h/%h", c, m_data_a,
                               m_data_b, md_lsb_m, md_msb_m); end
            total++; if (m_keep_a !== mk_m || m_keep_b !== mk_m || m_count_a !== mc_m ||
                         m_last_a !== ml_m) begin
               bad++; $display("FAIL rand_side cyc=%0d got k=%b c=%0d l=%b exp k=%b c=%0d l=%b",
                               c, m_keep_a, m_count_a, m_last_a, mk_m, mc_m, ml_m); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_word();
      test_partial();
      test_back_to_back();
      test_stall();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
